// File: rtl/act_if.sv
// Valid/ready handshake and data bundle for the activation stage.
// The master drives beats in and accepts results; the slave is act_unit.
interface act_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned CHANNELS   = 4
);

   logic                               in_valid;
   logic                               in_ready;
   logic [CHANNELS*2*DATA_WIDTH-1:0]   in_x;
   logic [1:0]                         in_mode;
   logic                               out_valid;
   logic                               out_ready;
   logic [CHANNELS*DATA_WIDTH-1:0]     out_y;
   logic [CHANNELS-1:0]                out_grad;

   modport master (
      output in_valid,
      output in_x,
      output in_mode,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_y,
      input  out_grad
   );

   modport slave (
      input  in_valid,
      input  in_x,
      input  in_mode,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_y,
      output out_grad
   );

endinterface

// File: rtl/act_unit.sv
// Multi-channel activation stage: saturating truncation of double-width accumulators
// followed by a per-beat selectable ReLU variant, derivative mask and saturation counter.
module act_unit #(
   parameter int unsigned            DATA_WIDTH    = 16,
   parameter int unsigned            FRAC_WIDTH    = 8,
   parameter int unsigned            CHANNELS      = 4,
   parameter int unsigned            LEAK_SHIFT    = 3,
   parameter logic [DATA_WIDTH-1:0]  CLIP_MAX      = 16'h0600,
   parameter int unsigned            SAT_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   act_if.slave                      bus,
   input  logic                      sat_clr,
   output logic [SAT_CNT_WIDTH-1:0]  sat_count
);

   localparam int unsigned W    = DATA_WIDTH;
   localparam int unsigned F    = FRAC_WIDTH;
   localparam int unsigned XW   = 2 * DATA_WIDTH;
   localparam int unsigned TopW = W - F + 1;
   localparam int unsigned PopW = $clog2(CHANNELS + 1);

   typedef enum logic [1:0] {
      ModeSat   = 2'b00,
      ModeRelu  = 2'b01,
      ModeLeaky = 2'b10,
      ModeClip  = 2'b11
   } mode_e;

   typedef struct packed {
      logic [W-1:0] y;
      logic         grad;
      logic         flag;
   } lane_res_t;

   // Saturate the accumulator to Q(W-F).F, then apply the selected activation.
   function automatic lane_res_t lane_eval(input logic [XW-1:0] x, input mode_e mode);
      lane_res_t           r;
      logic                neg;
      logic [TopW-1:0]     top;
      logic                ovf_pos;
      logic                ovf_neg;
      logic [W-1:0]        v;
      logic signed [W-1:0] v_s;
      logic signed [W-1:0] leak;
      logic                pos;
      logic                below_clip;

      neg     = x[XW-1];
      top     = x[XW-1 -: TopW];
      ovf_pos = !neg && (|top);
      ovf_neg = neg && !(&top);

      if (ovf_pos) begin
         v = {1'b0, {(W-1){1'b1}}};
      end else if (ovf_neg) begin
         v = {1'b1, {(W-1){1'b0}}};
      end else begin
         v = x[F +: W];
      end

      v_s        = $signed(v);
      leak       = v_s >>> LEAK_SHIFT;
      pos        = !neg && (|x);
      below_clip = v_s < $signed(CLIP_MAX);

      r = '0;
      case (mode)
         ModeSat: begin
            r.y    = v;
            r.grad = 1'b1;
            r.flag = ovf_pos || ovf_neg;
         end
         ModeRelu: begin
            r.y    = neg ? '0 : v;
            r.grad = pos;
            r.flag = ovf_pos;
         end
         ModeLeaky: begin
            r.y    = neg ? $unsigned(leak) : v;
            r.grad = !neg;
            r.flag = ovf_pos || ovf_neg;
         end
         ModeClip: begin
            r.y    = neg ? '0 : (below_clip ? v : CLIP_MAX);
            r.grad = pos && below_clip;
            r.flag = ovf_pos;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Stage 1: raw beat
   logic                    s1_valid_q;
   logic [CHANNELS*XW-1:0]  s1_x_q;
   mode_e                   s1_mode_q;

   // Stage 2: results
   logic                    s2_valid_q;
   logic [CHANNELS*W-1:0]   s2_y_q;
   logic [CHANNELS-1:0]     s2_grad_q;
   logic [CHANNELS*W-1:0]   s2_y_d;
   logic [CHANNELS-1:0]     s2_grad_d;

   logic [SAT_CNT_WIDTH-1:0] sat_count_q;
   logic [SAT_CNT_WIDTH-1:0] sat_count_d;
   logic [SAT_CNT_WIDTH:0]   sat_sum;
   logic [PopW-1:0]          flag_cnt;

   logic adv2;
   logic accept;

   lane_res_t lane_r [CHANNELS];

   assign adv2        = s1_valid_q && (!s2_valid_q || bus.out_ready);
   assign bus.in_ready = !s1_valid_q || adv2;
   assign accept      = bus.in_valid && bus.in_ready;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      assign lane_r[g] = lane_eval(s1_x_q[g*XW +: XW], s1_mode_q);
   end

   always_comb begin
      s2_y_d    = '0;
      s2_grad_d = '0;
      flag_cnt  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         s2_y_d[i*W +: W] = lane_r[i].y;
         s2_grad_d[i]     = lane_r[i].grad;
         flag_cnt         = flag_cnt + PopW'(lane_r[i].flag);
      end
   end

   // Extra carry bit detects overflow so the counter clamps instead of wrapping.
   assign sat_sum = {1'b0, sat_count_q} + (SAT_CNT_WIDTH+1)'(flag_cnt);

   always_comb begin
      sat_count_d = sat_count_q;
      if (sat_clr) begin
         sat_count_d = '0;
      end else if (adv2) begin
         sat_count_d = sat_sum[SAT_CNT_WIDTH] ? '1 : sat_sum[SAT_CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_mode_q  <= ModeSat;
      end else if (accept) begin
         s1_valid_q <= 1'b1;
         s1_x_q     <= bus.in_x;
         s1_mode_q  <= mode_e'(bus.in_mode);
      end else if (adv2) begin
         s1_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_y_q     <= '0;
         s2_grad_q  <= '0;
      end else if (adv2) begin
         s2_valid_q <= 1'b1;
         s2_y_q     <= s2_y_d;
         s2_grad_q  <= s2_grad_d;
      end else if (bus.out_ready) begin
         s2_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count_q <= '0;
      end else begin
         sat_count_q <= sat_count_d;
      end
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.out_y     = s2_y_q;
   assign bus.out_grad  = s2_grad_q;
   assign sat_count     = sat_count_q;

endmodule

// File: tb/tb_act_unit.sv
// Directed-vector bench for act_unit: modes, saturation, backpressure, counter clamp/clear
// and asynchronous reset with beats in flight.
module tb_act_unit;

   localparam int unsigned W   = 16;
   localparam int unsigned CH  = 4;
   localparam int unsigned XW  = 32;
   localparam int unsigned SCW = 16;

   logic           clk     = 1'b0;
   logic           rst_n   = 1'b1;
   logic           sat_clr = 1'b0;
   logic [SCW-1:0] sat_count;

   int n_cmp   = 0;
   int n_bad   = 0;
   int exp_sat = 0;

   act_if #(.DATA_WIDTH(W), .CHANNELS(CH)) bus ();

   act_unit #(
      .DATA_WIDTH    (W),
      .FRAC_WIDTH    (8),
      .CHANNELS      (CH),
      .LEAK_SHIFT    (3),
      .CLIP_MAX      (16'h0600),
      .SAT_CNT_WIDTH (SCW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .sat_clr   (sat_clr),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   localparam logic [CH*XW-1:0] OVF4 = {4{32'h0100_0000}};

   // Single beat into an empty pipeline; returns the first output and its latency in cycles.
   task automatic xfer(input logic [CH*XW-1:0] x, input logic [1:0] mode,
                       output logic [CH*W-1:0] y, output logic [CH-1:0] g, output int lat);
      bit done;
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_x      = x;
      bus.in_mode   = mode;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat  = -1;
      y    = 'x;
      g    = 'x;
      done = 1'b0;
      for (int n = 1; n <= 10 && !done; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            lat  = n;
            y    = bus.out_y;
            g    = bus.out_grad;
            done = 1'b1;
         end
      end
   endtask

   // Stream n identical beats at full rate; acc reports how many were accepted.
   task automatic stream(input logic [CH*XW-1:0] x, input logic [1:0] mode, input int n,
                         output int acc);
      logic rdy;
      acc = 0;
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_x      = x;
      bus.in_mode   = mode;
      bus.out_ready = 1'b1;
      for (int c = 0; c < n + 50 && acc < n; c++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) acc++;
         #1;
         if (acc == n) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_y !== '0 || bus.out_grad !== '0 ||
          sat_count !== '0 || bus.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_state: valid=%b y=%h grad=%b sat=%h rdy=%b, want 0/0/0/0/1",
                  bus.out_valid, bus.out_y, bus.out_grad, sat_count, bus.in_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_sat = 0;
   endtask

   task automatic test_relu();
      logic [CH*W-1:0] y;
      logic [CH-1:0]   g;
      int              lat;
      xfer({96'h0, 32'h0001_8000}, 2'b01, y, g, lat);
      n_cmp++;
      if (lat !== 2) begin
         n_bad++;
         $display("FAIL relu_latency: got %0d want 2", lat);
      end
      n_cmp++;
      if (y !== 64'h0000_0000_0000_0180 || g !== 4'b0001) begin
         n_bad++;
         $display("FAIL relu_value: y=%h grad=%b want 0000000000000180/0001", y, g);
      end
      n_cmp++;
      if (sat_count !== SCW'(exp_sat)) begin
         n_bad++;
         $display("FAIL relu_sat: got %0d want %0d", sat_count, exp_sat);
      end
   endtask

   task automatic test_saturate();
      logic [CH*W-1:0] y;
      logic [CH-1:0]   g;
      int              lat;
      xfer({96'h0, 32'h0100_0000}, 2'b01, y, g, lat);
      exp_sat += 1;
      n_cmp++;
      if (y !== 64'h7FFF || g !== 4'b0001 || sat_count !== SCW'(exp_sat)) begin
         n_bad++;
         $display("FAIL sat_pos_relu: y=%h grad=%b sat=%0d want 7fff/0001/%0d", y, g, sat_count,
                  exp_sat);
      end
      xfer({96'h0, 32'hFF00_0000}, 2'b00, y, g, lat);
      exp_sat += 1;
      n_cmp++;
      if (y !== 64'h8000 || g !== 4'b1111 || sat_count !== SCW'(exp_sat)) begin
         n_bad++;
         $display("FAIL sat_neg_plain: y=%h grad=%b sat=%0d want 8000/1111/%0d", y, g,
                  sat_count, exp_sat);
      end
      xfer({96'h0, 32'hFF00_0000}, 2'b01, y, g, lat);
      n_cmp++;
      if (y !== 64'h0 || g !== 4'b0000 || sat_count !== SCW'(exp_sat)) begin
         n_bad++;
         $display("FAIL sat_neg_relu: y=%h grad=%b sat=%0d want 0/0000/%0d", y, g, sat_count,
                  exp_sat);
      end
   endtask

   task automatic test_leaky();
      logic [CH*W-1:0] y;
      logic [CH-1:0]   g;
      int              lat;
      xfer({32'h0, 32'h8000_0000, 32'h0001_8000, 32'hFFFE_0000}, 2'b10, y, g, lat);
      exp_sat += 1;
      n_cmp++;
      if (y !== 64'h0000_F000_0180_FFC0 || g !== 4'b1010) begin
         n_bad++;
         $display("FAIL leaky_value: y=%h grad=%b want 0000f0000180ffc0/1010", y, g);
      end
      n_cmp++;
      if (sat_count !== SCW'(exp_sat)) begin
         n_bad++;
         $display("FAIL leaky_sat: got %0d want %0d", sat_count, exp_sat);
      end
   endtask

   task automatic test_clip();
      logic [CH*W-1:0] y;
      logic [CH-1:0]   g;
      int              lat;
      xfer({32'hFFFF_0000, 32'h0006_0000, 32'h0005_0000, 32'h0007_0000}, 2'b11, y, g, lat);
      n_cmp++;
      if (y !== 64'h0000_0600_0500_0600 || g !== 4'b0010) begin
         n_bad++;
         $display("FAIL clip_value: y=%h grad=%b want 0000060005000600/0010", y, g);
      end
      n_cmp++;
      if (sat_count !== SCW'(exp_sat)) begin
         n_bad++;
         $display("FAIL clip_sat: got %0d want %0d", sat_count, exp_sat);
      end
   endtask

   task automatic test_back_to_back();
      logic [CH*XW-1:0] bx [3];
      logic [1:0]       bm [3];
      logic [CH*W-1:0]  ey [3];
      logic [CH-1:0]    eg [3];
      logic             rdy;
      int               idx;
      int               nout;
      int               first;
      int               last;
      bx[0] = {96'h0, 32'h0001_8000}; bm[0] = 2'b01; ey[0] = 64'h0180; eg[0] = 4'b0001;
      bx[1] = {96'h0, 32'hFFFE_0000}; bm[1] = 2'b10; ey[1] = 64'hFFC0; eg[1] = 4'b1110;
      bx[2] = {96'h0, 32'h0007_0000}; bm[2] = 2'b11; ey[2] = 64'h0600; eg[2] = 4'b0000;

      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      idx           = 0;
      bus.in_valid  = 1'b1;
      bus.in_x      = bx[0];
      bus.in_mode   = bm[0];
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         if (c >= 2) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_y !== ey[0] || bus.out_grad !== eg[0] ||
                rdy !== 1'b0) begin
               n_bad++;
               $display("FAIL bp_hold c%0d: valid=%b y=%h grad=%b rdy=%b want 1/%h/%b/0", c,
                        bus.out_valid, bus.out_y, bus.out_grad, rdy, ey[0], eg[0]);
            end
         end
         @(posedge clk);
         if (rdy && idx < 3) idx++;
         #1;
         if (idx < 3) begin
            bus.in_x    = bx[idx];
            bus.in_mode = bm[idx];
         end
      end
      n_cmp++;
      if (idx !== 2) begin
         n_bad++;
         $display("FAIL bp_accepted: got %0d want 2", idx);
      end

      bus.out_ready = 1'b1;
      nout  = 0;
      first = -1;
      last  = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         if (bus.out_valid) begin
            if (nout < 3) begin
               n_cmp++;
               if (bus.out_y !== ey[nout] || bus.out_grad !== eg[nout]) begin
                  n_bad++;
                  $display("FAIL b2b_order[%0d]: y=%h grad=%b want %h/%b", nout, bus.out_y,
                           bus.out_grad, ey[nout], eg[nout]);
               end
            end
            if (first < 0) first = c;
            last = c;
            nout++;
         end
         @(posedge clk);
         if (rdy && idx < 3) idx++;
         #1;
         if (idx < 3) begin
            bus.in_x    = bx[idx];
            bus.in_mode = bm[idx];
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      n_cmp++;
      if (nout !== 3 || last - first !== 2 || idx !== 3) begin
         n_bad++;
         $display("FAIL b2b_count: outs=%0d span=%0d accepted=%0d want 3/2/3", nout,
                  last - first, idx);
      end
      n_cmp++;
      if (sat_count !== SCW'(exp_sat)) begin
         n_bad++;
         $display("FAIL b2b_sat: got %0d want %0d", sat_count, exp_sat);
      end
   endtask

   task automatic test_counter();
      int acc;
      @(posedge clk); #1;
      sat_clr = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      exp_sat = 0;
      @(negedge clk);
      n_cmp++;
      if (sat_count !== 16'h0000) begin
         n_bad++;
         $display("FAIL cnt_clear_idle: got %h want 0000", sat_count);
      end

      // 16383 beats x 4 flags + 2 flags = 0xFFFE
      stream(OVF4, 2'b00, 16383, acc);
      n_cmp++;
      if (acc !== 16383) begin
         n_bad++;
         $display("FAIL cnt_stream_accept: got %0d want 16383", acc);
      end
      stream({64'h0, 32'h0100_0000, 32'hFF00_0000}, 2'b00, 1, acc);
      @(negedge clk);
      n_cmp++;
      if (sat_count !== 16'hFFFE) begin
         n_bad++;
         $display("FAIL cnt_preload: got %h want fffe", sat_count);
      end
      stream(OVF4, 2'b00, 1, acc);
      @(negedge clk);
      n_cmp++;
      if (sat_count !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL cnt_clamp: got %h want ffff", sat_count);
      end
      stream(OVF4, 2'b10, 1, acc);
      @(negedge clk);
      n_cmp++;
      if (sat_count !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL cnt_no_wrap: got %h want ffff", sat_count);
      end

      // Clear coincides with the flagged beat moving into stage 2.
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_x      = OVF4;
      bus.in_mode   = 2'b00;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      sat_clr      = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      exp_sat = 0;
      @(negedge clk);
      n_cmp++;
      if (sat_count !== 16'h0000 || bus.out_valid !== 1'b1 || bus.out_y !== {4{16'h7FFF}}) begin
         n_bad++;
         $display("FAIL cnt_clear_wins: sat=%h valid=%b y=%h want 0000/1/7fff7fff7fff7fff",
                  sat_count, bus.out_valid, bus.out_y);
      end
   endtask

   task automatic test_reset_inflight();
      logic [CH*W-1:0] y;
      logic [CH-1:0]   g;
      int              lat;
      int              stale;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_x      = OVF4;
      bus.in_mode   = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      exp_sat += 4;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || sat_count !== SCW'(exp_sat)) begin
         n_bad++;
         $display("FAIL rst_prefill: valid=%b rdy=%b sat=%0d want 1/0/%0d", bus.out_valid,
                  bus.in_ready, sat_count, exp_sat);
      end
      #2 rst_n = 1'b0;
      #1;
      exp_sat = 0;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || sat_count !== '0 || bus.out_y !== '0 ||
          bus.out_grad !== '0 || bus.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_async: valid=%b sat=%h y=%h grad=%b rdy=%b want 0/0/0/0/1",
                  bus.out_valid, sat_count, bus.out_y, bus.out_grad, bus.in_ready);
      end
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      stale         = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) stale++;
      end
      n_cmp++;
      if (stale !== 0) begin
         n_bad++;
         $display("FAIL rst_stale: got %0d stale cycles want 0", stale);
      end
      xfer({96'h0, 32'h0005_0000}, 2'b11, y, g, lat);
      n_cmp++;
      if (lat !== 2 || y !== 64'h0500 || g !== 4'b0001 || sat_count !== SCW'(exp_sat)) begin
         n_bad++;
         $display("FAIL rst_first_beat: lat=%0d y=%h grad=%b sat=%0d want 2/0500/0001/%0d",
                  lat, y, g, sat_count, exp_sat);
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_mode   = 2'b00;
      bus.out_ready = 1'b0;
      test_reset();
      test_relu();
      test_saturate();
      test_leaky();
      test_clip();
      test_back_to_back();
      test_counter();
      test_reset_inflight();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
